// File: rtl/board_view_renderer_if.sv
// Board-memory read port, sprite-ROM read port and VGA pixel-write port of the
// board view renderer, bundled so the renderer sees them as one bus.
interface board_view_renderer_if #(
    parameter int BOARD_N  = 8,
    parameter int CELL_PX  = 28,
    parameter int COLOUR_W = 3
);
    localparam int CW   = $clog2(BOARD_N);
    localparam int PW   = $clog2(CELL_PX);
    localparam int SA_W = 4 + 2 * PW;

    logic [CW-1:0]       view_x;
    logic [CW-1:0]       view_y;
    logic [3:0]          data_out_view;
    logic [SA_W-1:0]     sprite_addr;
    logic [COLOUR_W-1:0] sprite_data;
    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                writeEn;

    modport master (
        output view_x, view_y, sprite_addr, x, y, colour, writeEn,
        input  data_out_view, sprite_data
    );

    modport slave (
        input  view_x, view_y, sprite_addr, x, y, colour, writeEn,
        output data_out_view, sprite_data
    );
endinterface

// File: rtl/board_view_renderer.sv
// Draws the game board (or one cell of it) into a VGA frame buffer, one pixel per
// cycle, fetching each cell's piece and then its sprite, with an optional select box.
module board_view_renderer #(
    parameter int                  BOARD_N       = 8,
    parameter int                  CELL_PX       = 28,
    parameter int                  ORIGIN_X      = 8,
    parameter int                  ORIGIN_Y      = 8,
    parameter int                  COLOUR_W      = 3,
    parameter logic [COLOUR_W-1:0] BG_COLOUR     = '0,
    parameter logic [COLOUR_W-1:0] SEL_COLOUR_P0 = COLOUR_W'(4),
    parameter logic [COLOUR_W-1:0] SEL_COLOUR_P1 = COLOUR_W'(1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [$clog2(BOARD_N)-1:0] upd_x,
    input  logic [$clog2(BOARD_N)-1:0] upd_y,
    input  logic [$clog2(BOARD_N)-1:0] box_x,
    input  logic [$clog2(BOARD_N)-1:0] box_y,
    input  logic                       current_player,
    input  logic                       winning_msg,
    output logic                       busy,
    output logic                       done,
    board_view_renderer_if.master      bus
);
    localparam int CW = $clog2(BOARD_N);
    localparam int PW = $clog2(CELL_PX);
    localparam logic [CW-1:0] CELL_LAST = CW'(BOARD_N - 1);
    localparam logic [PW-1:0] PX_LAST   = PW'(CELL_PX - 1);

    typedef enum logic [2:0] {IDLE, RD_CELL, LATCH, DRAW, DONE} state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] box_x_q, box_x_d;
    logic [CW-1:0] box_y_q, box_y_d;
    logic          player_q, player_d;
    logic          win_q, win_d;
    logic [CW-1:0] cx_q, cx_d;
    logic [CW-1:0] cy_q, cy_d;
    logic [PW-1:0] px_q, px_d;
    logic [PW-1:0] py_q, py_d;
    logic [3:0]    piece_q, piece_d;
    logic [8:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic          wr_q, wr_d;
    logic          box_pix_q, box_pix_d;
    logic          empty_q, empty_d;

    logic last_cell;
    logic on_border;

    always_comb begin
        last_cell = mode_q || ((cx_q == CELL_LAST) && (cy_q == CELL_LAST));
        on_border = (px_q == '0) || (px_q == PX_LAST) || (py_q == '0) || (py_q == PX_LAST);
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        player_d  = player_q;
        win_d     = win_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        px_d      = px_q;
        py_d      = py_q;
        piece_d   = piece_q;
        x_d       = x_q;
        y_d       = y_q;
        wr_d      = 1'b0;
        box_pix_d = box_pix_q;
        empty_d   = empty_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RD_CELL;
                    mode_d   = mode;
                    box_x_d  = box_x;
                    box_y_d  = box_y;
                    player_d = current_player;
                    win_d    = winning_msg;
                    cx_d     = mode ? upd_x : '0;
                    cy_d     = mode ? upd_y : '0;
                    px_d     = '0;
                    py_d     = '0;
                end
            end
            RD_CELL: state_d = LATCH;
            LATCH: begin
                piece_d = bus.data_out_view;
                state_d = DRAW;
            end
            DRAW: begin
                // Pixel attributes are staged one cycle so they line up with sprite_data.
                wr_d      = 1'b1;
                x_d       = 9'(ORIGIN_X) + 9'(cx_q) * 9'(CELL_PX) + 9'(px_q);
                y_d       = 8'(ORIGIN_Y) + 8'(cy_q) * 8'(CELL_PX) + 8'(py_q);
                box_pix_d = (cx_q == box_x_q) && (cy_q == box_y_q) && !win_q && on_border;
                empty_d   = (piece_q == 4'd0);
                if (px_q == PX_LAST) begin
                    px_d = '0;
                    if (py_q == PX_LAST) begin
                        py_d = '0;
                        if (last_cell) begin
                            state_d = DONE;
                        end else begin
                            state_d = RD_CELL;
                            if (cx_q == CELL_LAST) begin
                                cx_d = '0;
                                cy_d = cy_q + CW'(1);
                            end else begin
                                cx_d = cx_q + CW'(1);
                            end
                        end
                    end else begin
                        py_d = py_q + PW'(1);
                    end
                end else begin
                    px_d = px_q + PW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            box_x_q   <= '0;
            box_y_q   <= '0;
            player_q  <= 1'b0;
            win_q     <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            px_q      <= '0;
            py_q      <= '0;
            piece_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            wr_q      <= 1'b0;
            box_pix_q <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            box_x_q   <= box_x_d;
            box_y_q   <= box_y_d;
            player_q  <= player_d;
            win_q     <= win_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            px_q      <= px_d;
            py_q      <= py_d;
            piece_q   <= piece_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wr_q      <= wr_d;
            box_pix_q <= box_pix_d;
            empty_q   <= empty_d;
        end
    end

    // The sprite ROM answers during the write cycle, so the colour mux sits after the flops.
    always_comb begin
        bus.colour = '0;
        if (wr_q) begin
            if (box_pix_q)    bus.colour = player_q ? SEL_COLOUR_P1 : SEL_COLOUR_P0;
            else if (empty_q) bus.colour = BG_COLOUR;
            else              bus.colour = bus.sprite_data;
        end
    end

    assign bus.view_x      = cx_q;
    assign bus.view_y      = cy_q;
    assign bus.sprite_addr = {piece_q, py_q, px_q};
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.writeEn     = wr_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
endmodule

// File: tb/tb_board_view_renderer.sv
// Directed bench for board_view_renderer: table of single-cell renders plus
// full-redraw, mid-render interference and mid-render reset sequences.
module tb_board_view_renderer;
    localparam int N  = 8;
    localparam int CP = 28;
    localparam int OX = 8;
    localparam int OY = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] upd_x = '0, upd_y = '0, box_x = '0, box_y = '0;
    logic       current_player = 1'b0;
    logic       winning_msg = 1'b0;
    logic       busy, done;

    board_view_renderer_if #(.BOARD_N(N), .CELL_PX(CP), .COLOUR_W(3)) bus ();

    board_view_renderer #(
        .BOARD_N(N), .CELL_PX(CP), .ORIGIN_X(OX), .ORIGIN_Y(OY), .COLOUR_W(3),
        .BG_COLOUR(3'b000), .SEL_COLOUR_P0(3'b100), .SEL_COLOUR_P1(3'b001)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .upd_x(upd_x), .upd_y(upd_y), .box_x(box_x), .box_y(box_y),
        .current_player(current_player), .winning_msg(winning_msg),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Board memory and sprite ROM, both with one-cycle registered reads.
    logic [3:0] board [0:N-1][0:N-1];
    always @(posedge clk) bus.data_out_view <= board[bus.view_y][bus.view_x];
    always @(posedge clk) bus.sprite_data   <= bus.sprite_addr[2:0];

    int errors = 0, checks = 0, cyc = 0;
    int wr_cnt, done_cnt, done_cyc, mism, sel_cnt, done_nowr, start_cyc;
    int xmin, xmax, ymin, ymax, first_x, first_y, last_x, last_y;
    int ecx, ecy, epx, epy, m_mode, m_bx, m_by, m_pl, m_win;
    logic [2:0] sel_col;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                board[r][c] = 4'd0;
    endtask

    // Monitor: one sample 1 time unit after each rising edge; predicts the next pixel.
    initial begin
        int ex, ey, pc;
        logic [2:0] ec;
        logic bord;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.writeEn) begin
                ex = OX + ecx * CP + epx;
                ey = OY + ecy * CP + epy;
                pc = (ecx < N && ecy < N) ? int'(board[ecy][ecx]) : 0;
                bord = (epx == 0 || epx == CP - 1 || epy == 0 || epy == CP - 1);
                if (ecx == m_bx && ecy == m_by && m_win == 0 && bord) ec = m_pl ? 3'b001 : 3'b100;
                else if (pc == 0) ec = 3'b000;
                else ec = 3'(epx % 8);
                if (int'(bus.x) != ex || int'(bus.y) != ey || bus.colour != ec) mism++;
                if (wr_cnt == 0) begin
                    first_x = int'(bus.x);
                    first_y = int'(bus.y);
                end
                last_x = int'(bus.x);
                last_y = int'(bus.y);
                if (int'(bus.x) < xmin) xmin = int'(bus.x);
                if (int'(bus.x) > xmax) xmax = int'(bus.x);
                if (int'(bus.y) < ymin) ymin = int'(bus.y);
                if (int'(bus.y) > ymax) ymax = int'(bus.y);
                if (bus.colour == sel_col) sel_cnt++;
                wr_cnt++;
                epx++;
                if (epx == CP) begin
                    epx = 0;
                    epy++;
                    if (epy == CP) begin
                        epy = 0;
                        if (m_mode == 0) begin
                            ecx++;
                            if (ecx == N) begin
                                ecx = 0;
                                ecy++;
                            end
                        end
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!bus.writeEn) done_nowr++;
            end
        end
    end

    // Called on a falling edge; pulses start for one cycle and re-arms the monitor.
    task automatic start_render(input int md, input int ux, input int uy, input int bx,
                                input int by, input int pl, input int win, input int sc);
        mode = md[0];
        upd_x = 3'(ux);
        upd_y = 3'(uy);
        box_x = 3'(bx);
        box_y = 3'(by);
        current_player = pl[0];
        winning_msg = win[0];
        start = 1'b1;
        m_mode = md; m_bx = bx; m_by = by; m_pl = pl; m_win = win;
        ecx = md ? ux : 0;
        ecy = md ? uy : 0;
        epx = 0; epy = 0;
        wr_cnt = 0; done_cnt = 0; mism = 0; sel_cnt = 0; done_nowr = 0;
        xmin = 9999; xmax = -1; ymin = 9999; ymax = -1;
        sel_col = 3'(sc);
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        int md, ux, uy, bx, by, pl, win, piece, sc;
        int e_wr, e_lat, e_xmin, e_xmax, e_ymin, e_ymax, e_sel;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // ROM colour is px[2:0]; e_sel counts pixels of colour sc in the drawn cell.
        vecs[0] = '{1, 7, 0, 2, 3, 0, 0, 5, 4, 784, 787, 204, 231,   8,  35,  84};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 1, 9, 4, 784, 787,   8,  35,   8,  35,  84};
        vecs[2] = '{1, 4, 6, 4, 6, 1, 0, 0, 1, 784, 787, 120, 147, 176, 203, 108};
        vecs[3] = '{1, 5, 2, 5, 2, 0, 0, 0, 4, 784, 787, 148, 175,  64,  91, 108};
        vecs[4] = '{1, 3, 3, 3, 4, 0, 0, 0, 4, 784, 787,  92, 119,  92, 119,   0};
        vecs[5] = '{1, 6, 7, 6, 7, 1, 0, 2, 1, 784, 787, 176, 203, 204, 231, 212};

        clear_board();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_writeEn", int'(bus.writeEn), 0);
        check("rst_xy", int'(bus.x) + int'(bus.y), 0);
        check("rst_colour", int'(bus.colour), 0);
        check("rst_view", int'(bus.view_x) + int'(bus.view_y), 0);
        check("rst_sprite_addr", int'(bus.sprite_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            clear_board();
            board[vecs[i].uy][vecs[i].ux] = 4'(vecs[i].piece);
            start_render(vecs[i].md, vecs[i].ux, vecs[i].uy, vecs[i].bx, vecs[i].by,
                         vecs[i].pl, vecs[i].win, vecs[i].sc);
            wait_done(1000);
            check($sformatf("v%0d_done_count", i), done_cnt, 1);
            check($sformatf("v%0d_writes", i), wr_cnt, vecs[i].e_wr);
            check($sformatf("v%0d_latency", i), done_cyc - start_cyc, vecs[i].e_lat);
            check($sformatf("v%0d_xmin", i), xmin, vecs[i].e_xmin);
            check($sformatf("v%0d_xmax", i), xmax, vecs[i].e_xmax);
            check($sformatf("v%0d_ymin", i), ymin, vecs[i].e_ymin);
            check($sformatf("v%0d_ymax", i), ymax, vecs[i].e_ymax);
            check($sformatf("v%0d_sel_pixels", i), sel_cnt, vecs[i].e_sel);
            check($sformatf("v%0d_pixel_model", i), mism, 0);
            check($sformatf("v%0d_done_with_write", i), done_nowr, 0);
            $display("vector %0d: cell (%0d,%0d) writes=%0d latency=%0d sel=%0d",
                     i, vecs[i].ux, vecs[i].uy, wr_cnt, done_cyc - start_cyc, sel_cnt);
        end

        // Full redraw of an empty board, box on (2,3), player 0.
        clear_board();
        start_render(0, 0, 0, 2, 3, 0, 0, 4);
        wait_done(51000);
        check("full_done_count", done_cnt, 1);
        check("full_writes", wr_cnt, 50176);
        check("full_latency", done_cyc - start_cyc, 1 + 64 * 786);
        check("full_first_x", first_x, 8);
        check("full_first_y", first_y, 8);
        check("full_last_x", last_x, 231);
        check("full_last_y", last_y, 231);
        check("full_box_pixels", sel_cnt, 108);
        check("full_pixel_model", mism, 0);
        check("full_done_with_write", done_nowr, 0);
        check("full_idle_busy", int'(busy), 0);
        $display("full redraw: writes=%0d latency=%0d box=%0d", wr_cnt, done_cyc - start_cyc, sel_cnt);

        // Start, box and player changes while rendering must not disturb the render.
        clear_board();
        start_render(1, 1, 1, 1, 1, 0, 0, 4);
        repeat (100) @(negedge clk);
        box_x = 3'd5;
        current_player = 1'b1;
        mode = 1'b0;
        upd_x = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000);
        check("mid_done_count", done_cnt, 1);
        check("mid_writes", wr_cnt, 784);
        check("mid_latency", done_cyc - start_cyc, 787);
        check("mid_box_pixels", sel_cnt, 108);
        check("mid_pixel_model", mism, 0);
        check("mid_idle_busy", int'(busy), 0);
        $display("mid-render inputs: writes=%0d dones=%0d box=%0d", wr_cnt, done_cnt, sel_cnt);

        // Reset during cell 10 of a full redraw, then restart immediately.
        clear_board();
        board[1][2] = 4'd7;
        start_render(0, 0, 0, 0, 0, 0, 0, 4);
        begin
            int n = 0;
            while (wr_cnt < 10 * 784 + 50 && n < 9000) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_reached_cell10", int'(wr_cnt >= 10 * 784 + 50), 1);
        begin
            int wr_before;
            reset = 1'b1;
            wr_before = wr_cnt;
            @(negedge clk);
            check("midrst_writeEn", int'(bus.writeEn), 0);
            check("midrst_busy", int'(busy), 0);
            check("midrst_no_write", wr_cnt, wr_before);
            check("midrst_sprite_addr", int'(bus.sprite_addr), 0);
            check("midrst_x", int'(bus.x), 0);
            $display("reset at write %0d: busy=%0d writeEn=%0d", wr_before, busy, bus.writeEn);
        end
        reset = 1'b0;
        start_render(0, 0, 0, 0, 0, 0, 0, 4);
        check("restart_busy", int'(busy), 1);
        begin
            int n = 0;
            while (wr_cnt < 2 * 784 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        check("restart_writes", int'(wr_cnt >= 2 * 784), 1);
        check("restart_first_x", first_x, 8);
        check("restart_first_y", first_y, 8);
        check("restart_pixel_model", mism, 0);
        $display("restart: first write (%0d,%0d) writes=%0d", first_x, first_y, wr_cnt);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("final_busy", int'(busy), 0);
        check("final_writeEn", int'(bus.writeEn), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
